unitest_seq: RTL and testbench

UNITEST_SEQ -- requirements
Module: unitest_seq

---
 rtl/unitest_pkg.sv | 38 +++
 rtl/unitest_busif.sv | 46 ++++
 rtl/unitest_seq.sv | 218 +++++++++++++++++++++
 tb/tb_unitest_seq.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/unitest_pkg.sv
// Shared definitions for the pin-test sequencer: register map, CTRL bit
// positions and sequencer states.
package unitest_pkg;

    localparam logic [7:0] ADDR_CTRL     = 8'h10;
    localparam logic [7:0] ADDR_SETTLE   = 8'h11;
    localparam logic [7:0] ADDR_MISMATCH = 8'h12;
    localparam logic [7:0] ADDR_OE       = 8'h20;
    localparam logic [7:0] ADDR_OUT      = 8'h28;
    localparam logic [7:0] ADDR_EXPECT   = 8'h30;
    localparam logic [7:0] ADDR_MASK     = 8'h38;
    localparam logic [7:0] ADDR_LIVE     = 8'h40;
    localparam logic [7:0] ADDR_CAPTURE  = 8'h48;

    // CTRL write bits
    localparam int CTRL_START = 0;
    localparam int CTRL_CLEAR = 1;
    // CTRL read bits
    localparam int CTRL_BUSY  = 0;
    localparam int CTRL_ERROR = 1;
    localparam int CTRL_DONE  = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_COMPARE = 2'd3
    } state_t;

    // True when addr falls in the 8-byte bank selected by bank (addr[7:3])
    // and the byte index is below the number of implemented bytes.
    function automatic logic in_bank(input logic [7:0] addr,
                                     input logic [4:0] bank,
                                     input int         nb);
        return (addr[7:3] == bank) && (int'(addr[2:0]) < nb);
    endfunction

endpackage

// File: rtl/unitest_busif.sv
// Microcontroller bus front end: two-flop synchronizers on the strobes and
// data bus, plus edge detection on the synchronized strobes.
module unitest_busif
    import unitest_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ale,
    input  logic       write,
    input  logic       read,
    input  logic [7:0] data,
    output logic       ale_fall,
    output logic       write_rise,
    output logic       read_fall,
    output logic       read_lvl,
    output logic [7:0] data_s
);

    // {ale, write, read}; _p0/_p1 synchronize, _p2 holds the previous value
    logic [2:0] ctl_p0, ctl_p1, ctl_p2;
    logic [7:0] data_p0, data_p1;

    // Synchronizer chain and edge-history register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctl_p0  <= '0;
            ctl_p1  <= '0;
            ctl_p2  <= '0;
            data_p0 <= '0;
            data_p1 <= '0;
        end else begin
            ctl_p0  <= {ale, write, read};
            ctl_p1  <= ctl_p0;
            ctl_p2  <= ctl_p1;
            data_p0 <= data;
            data_p1 <= data_p0;
        end
    end

    assign ale_fall   =  ctl_p2[2] & ~ctl_p1[2];
    assign write_rise = ~ctl_p2[1] &  ctl_p1[1];
    assign read_fall  =  ctl_p2[0] & ~ctl_p1[0];
    assign read_lvl   =  ctl_p1[0];
    assign data_s     =  data_p1;

endmodule

// File: rtl/unitest_seq.sv
// ZIF-socket pin tester: byte-wide register file on a multiplexed
// microcontroller bus, tri-state pin drivers, and a settle/capture/compare
// sequencer with a sticky error flag and a saturating mismatch counter.
module unitest_seq
    import unitest_pkg::*;
#(
    parameter int NPINS = 48,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    inout  wire  [7:0]       data,
    input  logic             ale,
    input  logic             write,
    input  logic             read,
    inout  wire  [NPINS:1]   zif
);

    localparam int NB = NPINS / 8;

    logic             ale_fall, write_rise, read_fall, read_lvl;
    logic [7:0]       data_s;

    logic [7:0]       address;
    logic [7:0]       rbuf;
    logic [NPINS-1:0] oe, out_r, expect_r, mask_r, capture;
    logic [NPINS-1:0] zif_p0, zif_p1;
    logic [CNT_W-1:0] settle_r, cnt, mismatch_cnt;
    logic [CNT_W-1:0] mm_nxt;
    logic             error, done, err_nxt;
    logic             busy;
    state_t           state, state_nxt;

    logic             ctrl_wr, start, clear, cfg_wr, mismatch;
    logic [5:0]       bofs;
    logic [7:0]       rd_val;
    logic             rd_map;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    unitest_busif u_busif (
        .clk        (clk),
        .rst_n      (rst_n),
        .ale        (ale),
        .write      (write),
        .read       (read),
        .data       (data),
        .ale_fall   (ale_fall),
        .write_rise (write_rise),
        .read_fall  (read_fall),
        .read_lvl   (read_lvl),
        .data_s     (data_s)
    );

    assign bofs     = {address[2:0], 3'b000};
    assign ctrl_wr  = write_rise && (address == ADDR_CTRL);
    assign start    = ctrl_wr && data_s[CTRL_START];
    assign clear    = ctrl_wr && data_s[CTRL_CLEAR];
    // Configuration is frozen while a run is in progress
    assign cfg_wr   = write_rise && !busy;
    assign mismatch = |((capture ^ expect_r) & mask_r);

    // Address latch and configuration register writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            address  <= '0;
            settle_r <= '0;
            oe       <= '0;
            out_r    <= '0;
            expect_r <= '0;
            mask_r   <= '0;
        end else begin
            if (ale_fall)
                address <= data_s;
            if (cfg_wr) begin
                if (address == ADDR_SETTLE)
                    settle_r <= CNT_W'(data_s);
                if (in_bank(address, ADDR_OE[7:3], NB))
                    oe[bofs +: 8] <= data_s;
                if (in_bank(address, ADDR_OUT[7:3], NB))
                    out_r[bofs +: 8] <= data_s;
                if (in_bank(address, ADDR_EXPECT[7:3], NB))
                    expect_r[bofs +: 8] <= data_s;
                if (in_bank(address, ADDR_MASK[7:3], NB))
                    mask_r[bofs +: 8] <= data_s;
            end
        end
    end

    // Two-flop synchronizer on the socket pins (zif[k] lands in bit k-1)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zif_p0 <= '0;
            zif_p1 <= '0;
        end else begin
            zif_p0 <= zif;
            zif_p1 <= zif_p0;
        end
    end

    // Pin drivers: each pin follows its OUT bit when enabled, else floats
    for (genvar k = 1; k <= NPINS; k++) begin : g_pin
        assign zif[k] = (rst_n && oe[k-1]) ? out_r[k-1] : 1'bz;
    end

    // Read decode of the currently latched address
    always_comb begin
        rd_val = 8'h00;
        rd_map = 1'b0;
        if (address == ADDR_CTRL) begin
            rd_map             = 1'b1;
            rd_val[CTRL_BUSY]  = busy;
            rd_val[CTRL_ERROR] = error;
            rd_val[CTRL_DONE]  = done;
        end else if (address == ADDR_SETTLE) begin
            rd_map = 1'b1;
            rd_val = 8'(settle_r);
        end else if (address == ADDR_MISMATCH) begin
            rd_map = 1'b1;
            rd_val = 8'(mismatch_cnt);
        end else if (in_bank(address, ADDR_OE[7:3], NB)) begin
            rd_map = 1'b1;
            rd_val = oe[bofs +: 8];
        end else if (in_bank(address, ADDR_OUT[7:3], NB)) begin
            rd_map = 1'b1;
            rd_val = out_r[bofs +: 8];
        end else if (in_bank(address, ADDR_EXPECT[7:3], NB)) begin
            rd_map = 1'b1;
            rd_val = expect_r[bofs +: 8];
        end else if (in_bank(address, ADDR_MASK[7:3], NB)) begin
            rd_map = 1'b1;
            rd_val = mask_r[bofs +: 8];
        end else if (in_bank(address, ADDR_LIVE[7:3], NB)) begin
            rd_map = 1'b1;
            rd_val = zif_p1[bofs +: 8];
        end else if (in_bank(address, ADDR_CAPTURE[7:3], NB)) begin
            rd_map = 1'b1;
            rd_val = capture[bofs +: 8];
        end
    end

    // Read buffer snapshots the addressed register on the read strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rbuf <= '0;
        else if (read_fall)
            rbuf <= rd_val;
    end

    assign data = (rst_n && !read_lvl && rd_map) ? rbuf : 8'hzz;

    // Sequencer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Sequencer next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (start) state_nxt = ST_SETTLE;
            ST_SETTLE:  if (cnt == '0) state_nxt = ST_CAPTURE;
            ST_CAPTURE: state_nxt = ST_COMPARE;
            ST_COMPARE: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Sequencer outputs
    always_comb begin
        busy = (state != ST_IDLE);
    end

    // Error/count update: a clear lands first, a compare result on top of it
    always_comb begin
        err_nxt = clear ? 1'b0 : error;
        mm_nxt  = clear ? '0   : mismatch_cnt;
        if (state == ST_COMPARE && mismatch) begin
            err_nxt = 1'b1;
            mm_nxt  = sat_inc(mm_nxt);
        end
    end

    // Sequencer datapath: settle counter, capture, result flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            capture      <= '0;
            error        <= 1'b0;
            mismatch_cnt <= '0;
            done         <= 1'b0;
        end else begin
            error        <= err_nxt;
            mismatch_cnt <= mm_nxt;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cnt  <= settle_r;
                        done <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (cnt != '0)
                        cnt <= cnt - 1'b1;
                end
                ST_CAPTURE: capture <= zif_p1;
                ST_COMPARE: done <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_unitest_seq.sv
// Directed bench for unitest_seq: bus register access, pin drive, settle
// timing, mismatch detection, counter saturation and mid-run reset.
module tb_unitest_seq;

    localparam int NPINS = 48;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       ale   = 1'b0;
    logic       write = 1'b0;
    logic       read  = 1'b1;
    logic       tb_den  = 1'b0;
    logic [7:0] tb_dval = 8'h00;
    logic [7:0] tb_zen  = 8'h00;
    logic [7:0] tb_zval = 8'h00;

    wire [7:0]     data;
    wire [NPINS:1] zif;

    int checks = 0;
    int errors = 0;

    assign data = tb_den ? tb_dval : 8'hzz;

    for (genvar k = 1; k <= 8; k++) begin : g_ext
        assign zif[k] = tb_zen[k-1] ? tb_zval[k-1] : 1'bz;
    end

    unitest_seq #(.NPINS(NPINS), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .data  (data),
        .ale   (ale),
        .write (write),
        .read  (read),
        .zif   (zif)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_addr(input logic [7:0] a);
        tb_den  = 1'b1;
        tb_dval = a;
        ale     = 1'b1;
        tick(4);
        ale     = 1'b0;
        tick(4);
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] v);
        bus_addr(a);
        tb_dval = v;
        tick(3);
        write = 1'b1;
        tick(4);
        write = 1'b0;
        tick(3);
        tb_den = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [7:0] v);
        bus_addr(a);
        tb_den = 1'b0;
        tick(2);
        read = 1'b0;
        tick(5);
        v = data;
        read = 1'b1;
        tick(4);
    endtask

    // Issue a CTRL write and count cycles with busy high (bounded window)
    task automatic start_and_count(input logic [7:0] v, output int n);
        bus_addr(8'h10);
        tb_dval = v;
        tick(3);
        write = 1'b1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (dut.busy === 1'b1) n++;
        end
        write = 1'b0;
        tick(3);
        tb_den = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(2);
        bus_read(8'h10, v);
        checks++;
        if (v !== 8'h00) begin errors++; $display("FAIL reset_ctrl: got %02h expected 00", v); end
        bus_read(8'h11, v);
        checks++;
        if (v !== 8'h00) begin errors++; $display("FAIL reset_settle: got %02h expected 00", v); end
        bus_read(8'h12, v);
        checks++;
        if (v !== 8'h00) begin errors++; $display("FAIL reset_mismatch: got %02h expected 00", v); end
    endtask

    task automatic test_drive();
        logic [7:0] v;
        bus_write(8'h20, 8'hFF);
        bus_write(8'h28, 8'hA5);
        tick(2);
        checks++;
        if (zif[8:1] !== 8'hA5) begin errors++; $display("FAIL drive_pins: got %02h expected a5", zif[8:1]); end
        bus_read(8'h40, v);
        checks++;
        if (v !== 8'hA5) begin errors++; $display("FAIL drive_live: got %02h expected a5", v); end
        bus_read(8'h28, v);
        checks++;
        if (v !== 8'hA5) begin errors++; $display("FAIL drive_out_rb: got %02h expected a5", v); end
        bus_read(8'h20, v);
        checks++;
        if (v !== 8'hFF) begin errors++; $display("FAIL drive_oe_rb: got %02h expected ff", v); end
    endtask

    task automatic test_settle();
        logic [7:0] v;
        int n;
        bus_write(8'h11, 8'h03);
        bus_write(8'h30, 8'hA5);
        bus_write(8'h38, 8'hFF);
        start_and_count(8'h01, n);
        checks++;
        if (n != 6) begin errors++; $display("FAIL settle3_busy: got %0d cycles expected 6", n); end
        bus_read(8'h10, v);
        checks++;
        if (v !== 8'h04) begin errors++; $display("FAIL settle3_ctrl: got %02h expected 04", v); end
        bus_read(8'h12, v);
        checks++;
        if (v !== 8'h00) begin errors++; $display("FAIL settle3_mismatch: got %02h expected 00", v); end
        bus_read(8'h11, v);
        checks++;
        if (v !== 8'h03) begin errors++; $display("FAIL settle_rb: got %02h expected 03", v); end
        bus_write(8'h11, 8'h00);
        start_and_count(8'h01, n);
        checks++;
        if (n != 3) begin errors++; $display("FAIL settle0_busy: got %0d cycles expected 3", n); end
    endtask

    task automatic test_mismatch();
        logic [7:0] v;
        // Pin 1 released by the DUT and held low externally
        bus_write(8'h20, 8'hFE);
        tb_zval = 8'h00;
        tb_zen  = 8'h01;
        tick(4);
        bus_write(8'h10, 8'h01);
        tick(4);
        bus_read(8'h10, v);
        checks++;
        if (v !== 8'h06) begin errors++; $display("FAIL mm_ctrl: got %02h expected 06", v); end
        bus_read(8'h12, v);
        checks++;
        if (v !== 8'h01) begin errors++; $display("FAIL mm_count: got %02h expected 01", v); end
        bus_read(8'h48, v);
        checks++;
        if (v !== 8'hA4) begin errors++; $display("FAIL mm_capture: got %02h expected a4", v); end
        bus_write(8'h38, 8'hFE);
        bus_write(8'h10, 8'h01);
        tick(4);
        bus_read(8'h12, v);
        checks++;
        if (v !== 8'h01) begin errors++; $display("FAIL mm_masked_count: got %02h expected 01", v); end
        bus_read(8'h10, v);
        checks++;
        if (v !== 8'h06) begin errors++; $display("FAIL mm_masked_ctrl: got %02h expected 06", v); end
    endtask

    task automatic test_saturate();
        logic [7:0] v;
        int n;
        bus_write(8'h38, 8'hFF);
        for (int i = 0; i < 260; i++)
            bus_write(8'h10, 8'h01);
        tick(4);
        bus_read(8'h12, v);
        checks++;
        if (v !== 8'hFF) begin errors++; $display("FAIL sat_count: got %02h expected ff", v); end
        bus_write(8'h38, 8'hFE);
        start_and_count(8'h03, n);
        checks++;
        if (n != 3) begin errors++; $display("FAIL clr_start_busy: got %0d cycles expected 3", n); end
        bus_read(8'h12, v);
        checks++;
        if (v !== 8'h00) begin errors++; $display("FAIL clr_count: got %02h expected 00", v); end
        bus_read(8'h10, v);
        checks++;
        if (v !== 8'h04) begin errors++; $display("FAIL clr_ctrl: got %02h expected 04", v); end
    endtask

    task automatic test_reset_mid_run();
        logic [7:0] v;
        tb_zen = 8'h00;
        bus_write(8'h20, 8'hFF);
        bus_write(8'h11, 8'd200);
        bus_write(8'h10, 8'h01);
        checks++;
        if (dut.busy !== 1'b1) begin errors++; $display("FAIL run_busy: got %b expected 1", dut.busy); end
        bus_write(8'h28, 8'h3C);
        bus_read(8'h28, v);
        checks++;
        if (v !== 8'hA5) begin errors++; $display("FAIL busy_write_dropped: got %02h expected a5", v); end
        checks++;
        if (dut.busy !== 1'b1) begin errors++; $display("FAIL still_busy: got %b expected 1", dut.busy); end
        rst_n   = 1'b0;
        tb_zval = 8'h5A;
        tb_zen  = 8'hFF;
        tick(1);
        checks++;
        if (zif[8:1] !== 8'h5A) begin errors++; $display("FAIL reset_pins_hiz: got %02h expected 5a", zif[8:1]); end
        checks++;
        if (dut.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", dut.busy); end
        tb_zen = 8'h00;
        rst_n  = 1'b1;
        tick(2);
        bus_read(8'h48, v);
        checks++;
        if (v !== 8'h00) begin errors++; $display("FAIL reset_capture: got %02h expected 00", v); end
        bus_read(8'h10, v);
        checks++;
        if (v !== 8'h00) begin errors++; $display("FAIL reset_run_ctrl: got %02h expected 00", v); end
        bus_read(8'h28, v);
        checks++;
        if (v !== 8'h00) begin errors++; $display("FAIL reset_out: got %02h expected 00", v); end
    endtask

    initial begin
        test_reset();
        test_drive();
        test_settle();
        test_mismatch();
        test_saturate();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
